// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the PC, issuing reads on a req/addr_ok/data_ok bus
//   and holding the fetched {pc, inst, valid} in a one-entry buffer for the IF/ID register.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   stall_i                    IF/ID holding; the buffered instruction is not consumed
//   flush_i, redirect_pc_i     redirect to a new PC; in-flight fetch of the old path is dropped
//   inst_req_o, inst_addr_o    bus request and address (held until inst_addr_ok_i)
//   inst_addr_ok_i             address accepted
//   inst_data_ok_i, inst_rdata_i  read data return
//   if_pc_o, if_inst_o, if_valid_o  buffered instruction (zeros when not valid)
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_addr_ok_i,
   input  logic        inst_data_ok_i,
   input  logic [31:0] inst_rdata_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_addr;
   logic [31:0] r_buf_pc;
   logic [31:0] r_buf_inst;
   logic        r_buf_valid;
   logic        r_kill;
   logic        w_consume;
   assign w_consume = r_buf_valid & ~stall_i;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_req_addr  <= 32'h0;
         r_buf_pc    <= 32'h0;
         r_buf_inst  <= 32'h0;
         r_buf_valid <= 1'b0;
         r_kill      <= 1'b0;
      end else begin
         if (w_consume) r_buf_valid <= 1'b0;
         case (r_state)
            // a new fetch only starts once the buffer is free, so returning data never collides
            S_IDLE: if (!flush_i && (!r_buf_valid || w_consume)) begin
               r_req_addr <= r_pc;
               r_pc       <= r_pc + 32'd4;
               r_state    <= S_REQ;
            end
            S_REQ: if (inst_addr_ok_i) r_state <= S_WAIT;
            S_WAIT: if (inst_data_ok_i) begin
               if (!(r_kill || flush_i)) begin
                  r_buf_valid <= 1'b1;
                  r_buf_pc    <= r_req_addr;
                  r_buf_inst  <= inst_rdata_i;
               end
               r_kill  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // a transaction still outstanding after this edge belongs to the old path
         if (flush_i) begin
            r_pc        <= redirect_pc_i;
            r_buf_valid <= 1'b0;
            if (r_state == S_REQ || (r_state == S_WAIT && !inst_data_ok_i)) r_kill <= 1'b1;
         end
      end
   end
   assign inst_req_o  = (r_state == S_REQ);
   assign inst_addr_o = r_req_addr;
   assign if_valid_o  = r_buf_valid;
   assign if_pc_o     = r_buf_valid ? r_buf_pc : 32'h0;
   assign if_inst_o   = r_buf_valid ? r_buf_inst : 32'h0;
endmodule
